// File: rtl/io_trap_ctrl.sv
// Z80 IO-port trap controller: catches user-mode IO to a port window, raises a
// timed NMI, and tracks supervisor mode until the RETN-to-user handoff.
module io_trap_ctrl #(
    parameter int unsigned NMI_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic [7:0] addr,
    input  logic       io_direction,
    input  logic       last_isr_untrap,
    input  logic       new_isr,
    input  logic       trap_en,
    input  logic [7:0] trap_lo,
    input  logic [7:0] trap_hi,
    input  logic       clr_count,
    output logic       nmi_n,
    output logic       supervisor,
    output logic       ignore_next_isr,
    output logic [7:0] trap_port,
    output logic       trap_dir,
    output logic       trap_valid,
    output logic [7:0] trap_count
);

    typedef enum logic [1:0] {
        ST_USER,
        ST_NMI,
        ST_SUPER,
        ST_EXIT
    } state_t;

    localparam logic [3:0] LP_NMI_LOAD = 4'(NMI_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_nmi_cnt;
    logic       r_nmi_n;
    logic       r_supervisor;
    logic       r_ignore;
    logic [7:0] r_trap_port;
    logic       r_trap_dir;
    logic       r_trap_valid;
    logic [7:0] r_trap_count;

    logic       r_iorq_s1, r_iorq_s2, r_iorq_d;
    logic       r_m1_s1, r_m1_s2, r_m1_d;
    logic [2:0] r_arm;

    logic       w_io_event;
    logic       w_m1_fall;
    logic       w_in_window;
    logic       w_trap;
    logic       w_unused;

    assign w_unused = new_isr;

    // Edges are only trusted once the history flop holds a post-reset sample,
    // so a strobe already low at reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iorq_s1 <= 1'b1;
            r_iorq_s2 <= 1'b1;
            r_iorq_d  <= 1'b1;
            r_m1_s1   <= 1'b1;
            r_m1_s2   <= 1'b1;
            r_m1_d    <= 1'b1;
            r_arm     <= '0;
        end else begin
            r_iorq_s1 <= iorq_n;
            r_iorq_s2 <= r_iorq_s1;
            r_iorq_d  <= r_iorq_s2;
            r_m1_s1   <= m1_n;
            r_m1_s2   <= r_m1_s1;
            r_m1_d    <= r_m1_s2;
            r_arm     <= {r_arm[1:0], 1'b1};
        end
    end

    assign w_io_event  = r_arm[2] & r_iorq_d & ~r_iorq_s2 & r_m1_s2;
    assign w_m1_fall   = r_arm[2] & r_m1_d & ~r_m1_s2;
    assign w_in_window = (trap_lo <= addr) && (addr <= trap_hi);
    assign w_trap      = (r_state == ST_USER) && w_io_event && trap_en && w_in_window;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_USER;
            r_nmi_cnt    <= '0;
            r_nmi_n      <= 1'b1;
            r_supervisor <= 1'b0;
            r_ignore     <= 1'b0;
            r_trap_port  <= '0;
            r_trap_dir   <= 1'b0;
            r_trap_valid <= 1'b0;
            r_trap_count <= '0;
        end else begin
            case (r_state)
                ST_USER: begin
                    if (w_trap) begin
                        r_state      <= ST_NMI;
                        r_nmi_cnt    <= LP_NMI_LOAD;
                        r_nmi_n      <= 1'b0;
                        r_supervisor <= 1'b1;
                        r_ignore     <= 1'b1;
                        r_trap_port  <= addr;
                        r_trap_dir   <= io_direction;
                        r_trap_valid <= 1'b1;
                    end
                end
                ST_NMI: begin
                    if (r_nmi_cnt == '0) begin
                        r_state  <= ST_SUPER;
                        r_nmi_n  <= 1'b1;
                        r_ignore <= 1'b0;
                    end else begin
                        r_nmi_cnt <= r_nmi_cnt - 4'd1;
                    end
                end
                ST_SUPER: begin
                    if (last_isr_untrap) begin
                        r_state <= ST_EXIT;
                    end
                end
                ST_EXIT: begin
                    if (w_m1_fall) begin
                        r_state      <= ST_USER;
                        r_supervisor <= 1'b0;
                        r_trap_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_USER;
            endcase

            if (clr_count) begin
                r_trap_count <= w_trap ? 8'd1 : 8'd0;
            end else if (w_trap && (r_trap_count != 8'hFF)) begin
                r_trap_count <= r_trap_count + 8'd1;
            end
        end
    end

    assign nmi_n           = r_nmi_n;
    assign supervisor      = r_supervisor;
    assign ignore_next_isr = r_ignore;
    assign trap_port       = r_trap_port;
    assign trap_dir        = r_trap_dir;
    assign trap_valid      = r_trap_valid;
    assign trap_count      = r_trap_count;

endmodule

// File: tb/tb_io_trap_ctrl.sv
// Bench for io_trap_ctrl: directed and randomized IO cycles against a
// transaction-level trap model.
module tb_io_trap_ctrl;

    localparam int NMI = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       iorq_n;
    logic       m1_n;
    logic [7:0] addr;
    logic       io_direction;
    logic       last_isr_untrap;
    logic       new_isr;
    logic       trap_en;
    logic [7:0] trap_lo;
    logic [7:0] trap_hi;
    logic       clr_count;
    logic       nmi_n;
    logic       supervisor;
    logic       ignore_next_isr;
    logic [7:0] trap_port;
    logic       trap_dir;
    logic       trap_valid;
    logic [7:0] trap_count;

    int total = 0;
    int bad   = 0;

    bit         m_trap;
    int         m_count;
    logic [7:0] m_port;
    logic       m_dir;
    logic       m_valid;

    io_trap_ctrl #(.NMI_CYCLES(NMI)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .iorq_n          (iorq_n),
        .m1_n            (m1_n),
        .addr            (addr),
        .io_direction    (io_direction),
        .last_isr_untrap (last_isr_untrap),
        .new_isr         (new_isr),
        .trap_en         (trap_en),
        .trap_lo         (trap_lo),
        .trap_hi         (trap_hi),
        .clr_count       (clr_count),
        .nmi_n           (nmi_n),
        .supervisor      (supervisor),
        .ignore_next_isr (ignore_next_isr),
        .trap_port       (trap_port),
        .trap_dir        (trap_dir),
        .trap_valid      (trap_valid),
        .trap_count      (trap_count)
    );

    always #5 clk = ~clk;

    // One IO bus cycle; nmi_n/ignore are checked edge by edge, the record after.
    task automatic io_cycle(input logic [7:0] a, input logic d, input logic m1, input bit clr3);
        bit exp_trap;
        bit exp_low;
        exp_trap = !m_trap && trap_en && (trap_lo <= a) && (a <= trap_hi) && m1;
        @(negedge clk);
        addr = a; io_direction = d; m1_n = m1; iorq_n = 1'b0;
        for (int k = 1; k <= NMI + 4; k++) begin
            if (clr3 && k == 3) clr_count = 1'b1;
            @(posedge clk); #1;
            clr_count = 1'b0;
            exp_low = exp_trap && (k >= 3) && (k <= NMI + 2);
            total++;
            if ({nmi_n, ignore_next_isr} !== {!exp_low, exp_low}) begin
                bad++;
                $display("FAIL nmi_timing addr=%h edge=%0d nmi_n/ignore=%b%b expected=%b%b",
                         a, k, nmi_n, ignore_next_isr, !exp_low, exp_low);
            end
            if (k < NMI + 4) @(negedge clk);
        end
        if (exp_trap) begin
            m_trap = 1; m_port = a; m_dir = d; m_valid = 1;
            if (m_count < 255) m_count++;
        end
        if (clr3) m_count = exp_trap ? 1 : 0;
        total++;
        if ({trap_count, trap_port, trap_dir, trap_valid, supervisor} !==
            {8'(m_count), m_port, m_dir, m_valid, m_trap}) begin
            bad++;
            $display("FAIL trap_record addr=%h got cnt=%0d port=%h dir=%b v=%b sup=%b expected cnt=%0d port=%h dir=%b v=%b sup=%b",
                     a, trap_count, trap_port, trap_dir, trap_valid, supervisor,
                     m_count, m_port, m_dir, m_valid, m_trap);
        end
        @(negedge clk);
        iorq_n = 1'b1; m1_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic leave_super();
        if (!m_trap) return;
        @(negedge clk); last_isr_untrap = 1'b1;
        @(negedge clk); last_isr_untrap = 1'b0;
        total++;
        if (supervisor !== 1'b1) begin
            bad++;
            $display("FAIL exit_still_super supervisor=%b expected=1", supervisor);
        end
        m1_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        m_trap = 0; m_valid = 0;
        total++;
        if ({supervisor, trap_valid, ignore_next_isr, nmi_n} !== 4'b0001) begin
            bad++;
            $display("FAIL back_to_user sup/valid/ign/nmi_n=%b%b%b%b expected=0001",
                     supervisor, trap_valid, ignore_next_isr, nmi_n);
        end
        @(negedge clk); m1_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; iorq_n = 1'b1; m1_n = 1'b1; addr = '0; io_direction = 1'b0;
        last_isr_untrap = 1'b0; new_isr = 1'b0; trap_en = 1'b0; trap_lo = '0; trap_hi = '0;
        clr_count = 1'b0;
        m_trap = 0; m_count = 0; m_port = '0; m_dir = 1'b0; m_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({nmi_n, supervisor, ignore_next_isr, trap_port, trap_dir, trap_valid, trap_count} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_values nmi_n=%b sup=%b ign=%b port=%h dir=%b v=%b cnt=%0d expected 1 0 0 00 0 0 0",
                     nmi_n, supervisor, ignore_next_isr, trap_port, trap_dir, trap_valid, trap_count);
        end
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic_trap();
        trap_lo = 8'h40; trap_hi = 8'h4F; trap_en = 1'b1;
        io_cycle(8'h42, 1'b0, 1'b1, 1'b0);
        io_cycle(8'h42, 1'b1, 1'b1, 1'b0);
        leave_super();
        io_cycle(8'h42, 1'b0, 1'b1, 1'b0);
        trap_en = 1'b0;
        leave_super();
        trap_en = 1'b1;
    endtask

    task automatic test_no_trap();
        trap_lo = 8'h40; trap_hi = 8'h4F;
        io_cycle(8'h50, 1'b1, 1'b1, 1'b0);
        io_cycle(8'h3F, 1'b1, 1'b1, 1'b0);
        io_cycle(8'h42, 1'b0, 1'b0, 1'b0);
        io_cycle(8'h40, 1'b1, 1'b1, 1'b0);
        leave_super();
        io_cycle(8'h4F, 1'b0, 1'b1, 1'b0);
        leave_super();
        trap_lo = 8'h50; trap_hi = 8'h40;
        io_cycle(8'h48, 1'b0, 1'b1, 1'b0);
        trap_lo = 8'h40; trap_hi = 8'h4F;
    endtask

    task automatic test_random();
        logic [7:0] lo, hi, a;
        for (int i = 0; i < 60; i++) begin
            lo = 8'($urandom_range(0, 255));
            hi = 8'($urandom_range(0, 255));
            trap_lo = lo; trap_hi = hi;
            trap_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && lo <= hi) a = 8'($urandom_range(lo, hi));
            else a = 8'($urandom_range(0, 255));
            io_cycle(a, 1'($urandom_range(0, 1)),
                     m_trap ? 1'b1 : 1'($urandom_range(0, 7) != 0),
                     $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) != 0) leave_super();
        end
        leave_super();
    endtask

    task automatic test_saturate();
        trap_lo = 8'h40; trap_hi = 8'h4F; trap_en = 1'b1;
        while (m_count < 255) begin
            io_cycle(8'h42, 1'b0, 1'b1, 1'b0);
            leave_super();
        end
        io_cycle(8'h43, 1'b1, 1'b1, 1'b0);
        leave_super();
        io_cycle(8'h44, 1'b0, 1'b1, 1'b1);
        leave_super();
        io_cycle(8'h10, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_nmi();
        trap_lo = 8'h40; trap_hi = 8'h4F; trap_en = 1'b1;
        @(negedge clk);
        addr = 8'h42; io_direction = 1'b1; m1_n = 1'b1; iorq_n = 1'b0;
        repeat (4) @(posedge clk); #1;
        total++;
        if (nmi_n !== 1'b0) begin
            bad++;
            $display("FAIL nmi_before_reset nmi_n=%b expected=0", nmi_n);
        end
        #2 reset_n = 1'b0;
        #1;
        m_trap = 0; m_count = 0; m_port = '0; m_dir = 1'b0; m_valid = 1'b0;
        total++;
        if ({nmi_n, supervisor, ignore_next_isr, trap_port, trap_dir, trap_valid, trap_count} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL async_reset nmi_n=%b sup=%b ign=%b port=%h dir=%b v=%b cnt=%0d expected 1 0 0 00 0 0 0",
                     nmi_n, supervisor, ignore_next_isr, trap_port, trap_dir, trap_valid, trap_count);
        end
        @(negedge clk); reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            total++;
            if ({nmi_n, supervisor, trap_count} !== {1'b1, 1'b0, 8'h00}) begin
                bad++;
                $display("FAIL release_low_iorq edge=%0d nmi_n=%b sup=%b cnt=%0d expected 1 0 0",
                         k, nmi_n, supervisor, trap_count);
            end
        end
        @(negedge clk); iorq_n = 1'b1;
        repeat (3) @(posedge clk);
        io_cycle(8'h4A, 1'b1, 1'b1, 1'b0);
        leave_super();
    endtask

    initial begin
        test_reset();
        test_basic_trap();
        test_no_trap();
        test_random();
        test_saturate();
        test_reset_mid_nmi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
